// File: rtl/bmc_frame_sequencer.sv
// bmc_frame_sequencer
//
// Sits between the optical receiver's recovered half-bit stream and the BMC
// decoder. It hunts for the frame sync preamble and locks to it. It then
// deserializes BLOCK_HALVES half-bits per frame into one block and hands the
// block to the decoder through a one-entry valid/ready output register.
//
// While locked, each block is followed by a SYNC_LEN half-bit preamble check.
// A missed preamble is flywheeled through until MAX_MISS consecutive misses
// have been seen; the sequencer then drops lock and hunts again.
//
// Ports:
//   clk          system clock; all logic runs on the rising edge
//   rst          asynchronous active-low reset; release is synchronous to clk
//   i_half       recovered half-bit sample
//   i_half_valid qualifies i_half; one sample is taken per asserted cycle
//   i_ready      decoder accepts o_block when this and o_valid are both high
//   o_block      assembled block; the first half-bit after sync is the MSB
//   o_valid      o_block is valid
//   o_bmc_err    boundary violation found in the block on o_block
//   o_locked     sequencer is frame-locked
//   o_overrun    one-cycle pulse when a completed block is dropped
//   o_drop_cnt   saturating count of dropped blocks
module bmc_frame_sequencer #(
    parameter int                SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 8'b11101000,
    parameter int                BLOCK_HALVES = 48,
    parameter int                MAX_MISS     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_half,
    input  logic                    i_half_valid,
    input  logic                    i_ready,
    output logic [BLOCK_HALVES-1:0] o_block,
    output logic                    o_valid,
    output logic                    o_bmc_err,
    output logic                    o_locked,
    output logic                    o_overrun,
    output logic [15:0]             o_drop_cnt
);

    localparam int CNT_W    = 6;
    localparam int MISS_W   = (MAX_MISS < 3) ? 2 : $clog2(MAX_MISS + 1);
    localparam int NUM_BITS = BLOCK_HALVES / 2;

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        COLLECT    = 2'd1,
        SYNC_CHECK = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // The shift registers keep one fewer bit than the window they represent:
    // the incoming sample completes the window combinationally, so the
    // oldest bit never needs to be stored.
    logic [SYNC_LEN-2:0]     sync_reg, sync_next;
    logic [BLOCK_HALVES-2:0] asm_reg, asm_next;
    logic [CNT_W-1:0]        half_cnt_reg, half_cnt_next;
    logic [MISS_W-1:0]       miss_reg, miss_next;
    logic [BLOCK_HALVES-1:0] block_reg, block_next;
    logic                    valid_reg, valid_next;
    logic                    err_reg, err_next;
    logic                    locked_reg, locked_next;
    logic                    overrun_reg, overrun_next;
    logic [15:0]             drop_reg, drop_next;

    logic [SYNC_LEN-1:0]     sync_window;
    logic [BLOCK_HALVES-1:0] full_block;
    logic [NUM_BITS-2:0]     bnd_viol;
    logic                    block_err;
    logic                    block_done;

    assign sync_window = {sync_reg, i_half};
    assign full_block  = {asm_reg, i_half};

    // The second half of data bit k and the first half of bit k+1 must differ.
    // The sync-to-data boundary (ahead of bit 0) is deliberately not checked.
    generate
        for (genvar gi = 0; gi < NUM_BITS - 1; gi++) begin : g_bnd
            assign bnd_viol[gi] = ~(full_block[BLOCK_HALVES-2-2*gi] ^
                                    full_block[BLOCK_HALVES-3-2*gi]);
        end
    endgenerate

    assign block_err = |bnd_viol;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg     <= '0;
            asm_reg      <= '0;
            half_cnt_reg <= '0;
            miss_reg     <= '0;
            block_reg    <= '0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            locked_reg   <= 1'b0;
            overrun_reg  <= 1'b0;
            drop_reg     <= '0;
        end else begin
            sync_reg     <= sync_next;
            asm_reg      <= asm_next;
            half_cnt_reg <= half_cnt_next;
            miss_reg     <= miss_next;
            block_reg    <= block_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
            locked_reg   <= locked_next;
            overrun_reg  <= overrun_next;
            drop_reg     <= drop_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sync_next     = sync_reg;
        asm_next      = asm_reg;
        half_cnt_next = half_cnt_reg;
        miss_next     = miss_reg;
        block_next    = block_reg;
        valid_next    = valid_reg;
        err_next      = err_reg;
        locked_next   = locked_reg;
        overrun_next  = 1'b0;
        drop_next     = drop_reg;
        block_done    = 1'b0;

        // The handshake runs every cycle, independent of i_half_valid.
        if (valid_reg && i_ready) begin
            valid_next = 1'b0;
        end

        if (i_half_valid) begin
            case (state_reg)
                HUNT: begin
                    sync_next = sync_window[SYNC_LEN-2:0];
                    if (sync_window == SYNC_PATTERN) begin
                        state_next    = COLLECT;
                        half_cnt_next = '0;
                        locked_next   = 1'b1;
                        miss_next     = '0;
                    end
                end
                COLLECT: begin
                    asm_next = full_block[BLOCK_HALVES-2:0];
                    if (half_cnt_reg == CNT_W'(BLOCK_HALVES - 1)) begin
                        block_done    = 1'b1;
                        state_next    = SYNC_CHECK;
                        half_cnt_next = '0;
                    end else begin
                        half_cnt_next = half_cnt_reg + 1'b1;
                    end
                end
                SYNC_CHECK: begin
                    sync_next = sync_window[SYNC_LEN-2:0];
                    if (half_cnt_reg == CNT_W'(SYNC_LEN - 1)) begin
                        half_cnt_next = '0;
                        if (sync_window == SYNC_PATTERN) begin
                            miss_next  = '0;
                            state_next = COLLECT;
                        end else if (miss_reg != MISS_W'(MAX_MISS - 1)) begin
                            // Flywheel: assume the frame is still aligned.
                            miss_next  = miss_reg + 1'b1;
                            state_next = COLLECT;
                        end else begin
                            miss_next   = '0;
                            state_next  = HUNT;
                            locked_next = 1'b0;
                            sync_next   = '0;
                        end
                    end else begin
                        half_cnt_next = half_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end

        if (block_done) begin
            if (!valid_reg || i_ready) begin
                block_next = full_block;
                err_next   = block_err;
                valid_next = 1'b1;
            end else begin
                // Output slot still occupied: keep the older block, drop this one.
                overrun_next = 1'b1;
                if (drop_reg != 16'hFFFF) begin
                    drop_next = drop_reg + 16'd1;
                end
            end
        end
    end

    assign o_block    = block_reg;
    assign o_valid    = valid_reg;
    assign o_bmc_err  = err_reg;
    assign o_locked   = locked_reg;
    assign o_overrun  = overrun_reg;
    assign o_drop_cnt = drop_reg;

endmodule

// File: tb/tb_bmc_frame_sequencer.sv
// Directed testbench for bmc_frame_sequencer.
module tb_bmc_frame_sequencer;

    logic        clk;
    logic        rst;
    logic        i_half;
    logic        i_half_valid;
    logic        i_ready;
    logic [47:0] o_block;
    logic        o_valid;
    logic        o_bmc_err;
    logic        o_locked;
    logic        o_overrun;
    logic [15:0] o_drop_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] SYNC = 8'b11101000;
    localparam logic [7:0] BAD  = 8'h00;

    bmc_frame_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .i_half       (i_half),
        .i_half_valid (i_half_valid),
        .i_ready      (i_ready),
        .o_block      (o_block),
        .o_valid      (o_valid),
        .o_bmc_err    (o_bmc_err),
        .o_locked     (o_locked),
        .o_overrun    (o_overrun),
        .o_drop_cnt   (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // BMC encoding, MSB data bit first. Every bit starts with a transition
    // from the previous half; a 1 adds a mid-bit transition.
    function automatic logic [47:0] bmc_encode(input logic [23:0] d);
        logic [47:0] r;
        logic        lvl;
        logic        h1;
        logic        h2;
        r   = '0;
        lvl = 1'b0;   // last half of the preamble
        for (int i = 0; i < 24; i++) begin
            h1 = ~lvl;
            h2 = d[23-i] ? ~h1 : h1;
            r[47-2*i] = h1;
            r[46-2*i] = h2;
            lvl = h2;
        end
        return r;
    endfunction

    task automatic idle();
        i_half_valid = 1'b0;
        i_half       = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send_half(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) idle();
        end
        i_half       = b;
        i_half_valid = 1'b1;
        @(posedge clk);
        #1;
        i_half_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_half(v[i], gaps);
    endtask

    task automatic send_block(input logic [47:0] v, input bit gaps);
        for (int i = 47; i >= 0; i--) send_half(v[i], gaps);
    endtask

    // Sends a block, then checks the hand-off one cycle after the last half.
    task automatic block_and_check(input string tag, input logic [47:0] v, input logic exp_err);
        send_block(v, 1'b0);
        check({tag, "_valid"}, 48'(o_valid), 48'd1);
        check({tag, "_block"}, o_block, v);
        check({tag, "_err"}, 48'(o_bmc_err), 48'(exp_err));
        $display("txn %s: block=%012h err=%0b locked=%0b", tag, o_block, o_bmc_err, o_locked);
    endtask

    logic [47:0] blk_a5, blk_flip, blk_a, blk_b, blk_c, blk_d;

    initial begin
        rst          = 1'b0;
        i_half       = 1'b0;
        i_half_valid = 1'b0;
        i_ready      = 1'b1;
        blk_a5   = bmc_encode(24'hA5A5A5);
        blk_flip = blk_a5 ^ (48'h1 << 45);
        blk_a    = bmc_encode(24'h123456);
        blk_b    = bmc_encode(24'hFEDCBA);
        blk_c    = bmc_encode(24'h0F0F0F);
        blk_d    = bmc_encode(24'h3C9E01);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  48'(o_valid), 48'd0);
        check("rst_locked", 48'(o_locked), 48'd0);
        check("rst_block",  o_block, 48'd0);
        check("rst_drop",   48'(o_drop_cnt), 48'd0);
        rst = 1'b1;
        idle();

        // Lock and deliver one clean block.
        send_byte(8'h00, 1'b0);
        check("prelock_locked", 48'(o_locked), 48'd0);
        send_byte(SYNC, 1'b0);
        check("lock_locked", 48'(o_locked), 48'd1);
        block_and_check("a5", blk_a5, 1'b0);
        idle();
        check("a5_valid_clear", 48'(o_valid), 48'd0);

        // Boundary violation at position 45.
        send_byte(SYNC, 1'b0);
        block_and_check("flip45", blk_flip, 1'b1);
        idle();

        // Overrun: decoder stalls across two frames.
        i_ready = 1'b0;
        send_byte(SYNC, 1'b0);
        block_and_check("ovr_first", blk_a, 1'b0);
        send_byte(SYNC, 1'b0);
        send_block(blk_b, 1'b0);
        check("ovr_pulse", 48'(o_overrun), 48'd1);
        check("ovr_drop",  48'(o_drop_cnt), 48'd1);
        check("ovr_held",  o_block, blk_a);
        check("ovr_valid", 48'(o_valid), 48'd1);
        $display("txn overrun: drop_cnt=%0d block=%012h", o_drop_cnt, o_block);
        idle();
        check("ovr_pulse_end", 48'(o_overrun), 48'd0);
        check("ovr_still_held", o_block, blk_a);
        i_ready = 1'b1;
        idle();
        check("ovr_delivered", 48'(o_valid), 48'd0);

        // Flywheel through two bad syncs, then a good one resets the miss count.
        send_byte(BAD, 1'b0);
        block_and_check("fly1", blk_c, 1'b0);
        send_byte(BAD, 1'b0);
        block_and_check("fly2", blk_d, 1'b0);
        check("fly2_locked", 48'(o_locked), 48'd1);
        send_byte(SYNC, 1'b0);
        block_and_check("fly_good", blk_a, 1'b0);
        send_byte(BAD, 1'b0);
        block_and_check("fly3", blk_b, 1'b0);
        send_byte(BAD, 1'b0);
        block_and_check("fly4", blk_c, 1'b0);
        check("miss_reset_locked", 48'(o_locked), 48'd1);

        // Third consecutive miss drops lock.
        send_byte(BAD, 1'b0);
        check("unlock_locked", 48'(o_locked), 48'd0);
        send_block(blk_d, 1'b0);
        check("unlock_no_block", 48'(o_valid), 48'd0);
        send_byte(8'h00, 1'b0);
        send_byte(SYNC, 1'b0);
        check("relock_locked", 48'(o_locked), 48'd1);
        block_and_check("relock", blk_a5, 1'b0);

        // Gapped input gives the same result as gap-free input.
        send_byte(SYNC, 1'b1);
        send_block(blk_flip, 1'b1);
        check("gap_valid", 48'(o_valid), 48'd1);
        check("gap_block", o_block, blk_flip);
        check("gap_err",   48'(o_bmc_err), 48'd1);
        $display("txn gap: block=%012h err=%0b", o_block, o_bmc_err);
        idle();

        // Asynchronous reset with a block pending.
        i_ready = 1'b0;
        send_byte(SYNC, 1'b0);
        block_and_check("pend", blk_b, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("arst_valid",  48'(o_valid), 48'd0);
        check("arst_block",  o_block, 48'd0);
        check("arst_locked", 48'(o_locked), 48'd0);
        check("arst_drop",   48'(o_drop_cnt), 48'd0);
        check("arst_err",    48'(o_bmc_err), 48'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        i_ready = 1'b1;
        idle();
        check("post_rst_locked", 48'(o_locked), 48'd0);
        send_byte(SYNC, 1'b0);
        check("post_rst_hunt_lock", 48'(o_locked), 48'd1);
        block_and_check("post_rst", blk_d, 1'b0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
